// File: rtl/zjh_cmp_pkg.sv
// Shared types and helpers for the sequential multi-nibble magnitude comparator.
// Result vectors are ordered {QAGB, QASB, QAEB}.
package zjh_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_LT   = 3'b010;
    localparam logic [2:0] RES_EQ   = 3'b001;
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_BOTH = 3'b110;

    // 74HC85 cascade priority: IAEB dominates, conflicting/absent GT/LT pass through inverted-ish.
    function automatic logic [2:0] cascade_resolve(input logic iagb, input logic iasb,
                                                   input logic iaeb);
        if (iaeb) begin
            return RES_EQ;
        end
        case ({iagb, iasb})
            2'b10:   return RES_GT;
            2'b01:   return RES_LT;
            2'b11:   return RES_NONE;
            default: return RES_BOTH;
        endcase
    endfunction

endpackage

// File: rtl/zjh_nib_cmp.sv
// Combinational unsigned 4-bit magnitude compare of one nibble pair.
module zjh_nib_cmp (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       gt,
    output logic       lt,
    output logic       eq
);

    always_comb begin
        gt = (a > b);
        lt = (a < b);
        eq = (a == b);
    end

endmodule

// File: rtl/zjh_cmp_seq.sv
// Sequential MSB-first nibble-serial magnitude comparator with 74HC85-style cascade result
// and a start/done handshake.
module zjh_cmp_seq
    import zjh_cmp_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   A,
    input  logic [4*NIBBLES-1:0]   B,
    input  logic                   IAGB,
    input  logic                   IASB,
    input  logic                   IAEB,
    output logic                   busy,
    output logic                   done,
    output logic                   QAGB,
    output logic                   QASB,
    output logic                   QAEB
);

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t            state;
    logic [W-1:0]      a_reg;
    logic [W-1:0]      b_reg;
    logic [2:0]        casc_reg;
    logic [2:0]        res_reg;
    logic [IDXW-1:0]   idx;
    logic [3:0]        a_nib;
    logic [3:0]        b_nib;
    logic              nib_gt;
    logic              nib_lt;
    logic              nib_eq;

    assign a_nib = a_reg[4*idx +: 4];
    assign b_nib = b_reg[4*idx +: 4];

    zjh_nib_cmp u_nib_cmp (
        .a  (a_nib),
        .b  (b_nib),
        .gt (nib_gt),
        .lt (nib_lt),
        .eq (nib_eq)
    );

    assign {QAGB, QASB, QAEB} = res_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            res_reg  <= '0;
            idx      <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            casc_reg <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg    <= A;
                        b_reg    <= B;
                        casc_reg <= {IAGB, IASB, IAEB};
                        idx      <= IDXW'(NIBBLES - 1);
                        busy     <= 1'b1;
                        state    <= SCAN;
                    end else begin
                        state <= IDLE;
                    end
                end
                SCAN: begin
                    // start is deliberately not examined here: a scan cannot be restarted.
                    if (nib_gt) begin
                        res_reg <= RES_GT;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else if (nib_lt) begin
                        res_reg <= RES_LT;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else if (nib_eq && (idx != '0)) begin
                        idx <= idx - 1'b1;
                    end else begin
                        res_reg <= cascade_resolve(casc_reg[2], casc_reg[1], casc_reg[0]);
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zjh_cmp_seq.sv
// Scoreboard bench for zjh_cmp_seq (NIBBLES=4): expected result/latency queued at start, checked at done.
module tb_zjh_cmp_seq;

    localparam int N = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [15:0]   A;
    logic [15:0]   B;
    logic          IAGB;
    logic          IASB;
    logic          IAEB;
    logic          busy;
    logic          done;
    logic          QAGB;
    logic          QASB;
    logic          QAEB;

    typedef struct {
        logic [2:0] q;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    zjh_cmp_seq #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .IAGB  (IAGB),
        .IASB  (IASB),
        .IAEB  (IAEB),
        .busy  (busy),
        .done  (done),
        .QAGB  (QAGB),
        .QASB  (QASB),
        .QAEB  (QAEB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: MSB-first scan then 74HC85 cascade priority.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic gb, input logic sl, input logic eb);
        exp_t r;
        logic [3:0] na, nb;
        for (int i = N - 1; i >= 0; i--) begin
            na = a[4*i +: 4];
            nb = b[4*i +: 4];
            if (na != nb) begin
                r.q   = (na > nb) ? 3'b100 : 3'b010;
                r.lat = N - i;
                return r;
            end
        end
        r.lat = N;
        if (eb)              r.q = 3'b001;
        else if (gb && !sl)  r.q = 3'b100;
        else if (!gb && sl)  r.q = 3'b010;
        else if (gb && sl)   r.q = 3'b000;
        else                 r.q = 3'b110;
        return r;
    endfunction

    // Waits for done with a cycle budget; notes whether Q moved before done.
    task automatic wait_done(input logic [2:0] q_prev, output int cycles,
                             output bit timeout, output bit stable);
        cycles  = 0;
        timeout = 1'b1;
        stable  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            cycles++;
            if (done) begin
                timeout = 1'b0;
                break;
            end
            if ({QAGB, QASB, QAEB} !== q_prev) stable = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        A = '0; B = '0; IAGB = 1'b0; IASB = 1'b0; IAEB = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, done} !== 2'b00) $display("FAIL reset_ctrl: busy/done=%b expected 00", {busy, done});
        else passed++;
        total++;
        if ({QAGB, QASB, QAEB} !== 3'b000) $display("FAIL reset_q: Q=%b expected 000", {QAGB, QASB, QAEB});
        else passed++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // One complete operation: expectation pushed on start, popped and compared at done.
    task automatic test_single_op(input string name, input logic [15:0] a, input logic [15:0] b,
                                  input logic gb, input logic sl, input logic eb,
                                  input logic [2:0] exp_q, input int exp_lat);
        exp_t e;
        logic [2:0] q_prev;
        int cycles;
        bit timeout, stable;
        sb.push_back('{q: exp_q, lat: exp_lat});
        q_prev = {QAGB, QASB, QAEB};
        A = a; B = b; IAGB = gb; IASB = sl; IAEB = eb;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = ~a; B = ~b; IAGB = ~gb; IASB = ~sl; IAEB = ~eb;
        total++;
        if (exp_lat > 1 && {busy, done} !== 2'b10)
            $display("FAIL %s_busy: busy/done=%b expected 10", name, {busy, done});
        else if (exp_lat == 1 && busy !== 1'b1)
            $display("FAIL %s_busy: busy=%b expected 1", name, busy);
        else passed++;
        if (exp_lat == 1) begin
            cycles = 0; timeout = 1'b1; stable = 1'b1;
            @(posedge clk); #1;
            cycles = 1;
            if (done) timeout = 1'b0;
        end else begin
            wait_done(q_prev, cycles, timeout, stable);
        end
        e = sb.pop_front();
        total++;
        if (timeout || cycles != e.lat)
            $display("FAIL %s_latency: got %0d (timeout=%0d) expected %0d", name, cycles, timeout, e.lat);
        else passed++;
        total++;
        if ({QAGB, QASB, QAEB} !== e.q)
            $display("FAIL %s_q: Q=%b expected %b", name, {QAGB, QASB, QAEB}, e.q);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL %s_busy_done: busy=%b expected 0", name, busy);
        else passed++;
        total++;
        if (!stable) $display("FAIL %s_q_hold: Q changed before done (prev %b)", name, q_prev);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || {QAGB, QASB, QAEB} !== e.q)
            $display("FAIL %s_pulse: done=%b Q=%b expected done 0 Q %b", name, done, {QAGB, QASB, QAEB}, e.q);
        else passed++;
    endtask

    task automatic test_cascade;
        test_single_op("casc_both1", 16'hABCD, 16'hABCD, 1'b1, 1'b1, 1'b0, 3'b000, 4);
        test_single_op("casc_both0", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 3'b110, 4);
        test_single_op("casc_gt",    16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 3'b100, 4);
        test_single_op("casc_eq_ovr",16'h5A5A, 16'h5A5A, 1'b1, 1'b1, 1'b1, 3'b001, 4);
    endtask

    task automatic test_start_ignored;
        exp_t e;
        int cycles, dones;
        bit timeout, stable;
        sb.push_back('{q: 3'b100, lat: 3});
        A = 16'h00F0; B = 16'h0010; IAGB = 1'b0; IASB = 1'b0; IAEB = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        A = 16'h0000; B = 16'hFFFF; IAEB = 1'b0;
        wait_done({QAGB, QASB, QAEB}, cycles, timeout, stable);
        start = 1'b0;
        e = sb.pop_front();
        total++;
        if (timeout || cycles != e.lat || {QAGB, QASB, QAEB} !== e.q)
            $display("FAIL start_ignored: lat=%0d Q=%b expected lat %0d Q %b",
                     cycles, {QAGB, QASB, QAEB}, e.lat, e.q);
        else passed++;
        @(posedge clk); #1;
        // Mid-scan reset on a fresh operation.
        A = 16'h1234; B = 16'h1234; IAEB = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({busy, done, QAGB, QASB, QAEB} !== 5'b00000)
            $display("FAIL midscan_reset: busy,done,Q=%b expected 00000", {busy, done, QAGB, QASB, QAEB});
        else passed++;
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        total++;
        if (dones != 0) $display("FAIL midscan_no_done: activity cycles=%0d expected 0", dones);
        else passed++;
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int cycles;
        bit timeout, stable;
        sb.push_back('{q: 3'b100, lat: 1});
        A = 16'h5000; B = 16'h4000; IAGB = 1'b0; IASB = 1'b0; IAEB = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        e = sb.pop_front();
        total++;
        if (done !== 1'b1 || {QAGB, QASB, QAEB} !== e.q)
            $display("FAIL b2b_first: done=%b Q=%b expected 1 %b", done, {QAGB, QASB, QAEB}, e.q);
        else passed++;
        // Start during the done cycle.
        sb.push_back('{q: 3'b010, lat: 4});
        A = 16'h0001; B = 16'h0002; IAEB = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if ({busy, done} !== 2'b10) $display("FAIL b2b_accept: busy/done=%b expected 10", {busy, done});
        else passed++;
        wait_done(3'b100, cycles, timeout, stable);
        e = sb.pop_front();
        total++;
        if (timeout || cycles != e.lat || {QAGB, QASB, QAEB} !== e.q)
            $display("FAIL b2b_second: lat=%0d Q=%b expected lat %0d Q %b",
                     cycles, {QAGB, QASB, QAEB}, e.lat, e.q);
        else passed++;
        total++;
        if (!stable) $display("FAIL b2b_hold: first result not held during second scan");
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        exp_t m;
        logic [15:0] a, b;
        logic [1:0] k;
        for (int i = 0; i < 10; i++) begin
            a = 16'($urandom);
            b = a;
            k = 2'($urandom_range(0, 3));
            if (i % 3 != 0) b[4*k +: 4] = 4'($urandom);
            m = model(a, b, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
            test_single_op("rand", a, b, m.q[2] ^ 1'b0, 1'b0, 1'b0,
                           model(a, b, m.q[2], 1'b0, 1'b0).q, m.lat);
        end
    endtask

    initial begin
        test_reset();
        test_single_op("all_equal", 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b1, 3'b001, 4);
        test_single_op("msb_diff",  16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b0, 3'b100, 1);
        test_single_op("mid_diff",  16'h12A4, 16'h12B4, 1'b0, 1'b0, 1'b0, 3'b010, 3);
        test_cascade();
        test_start_ignored();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
